// File: rtl/yj_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags.
// Read data is either first-word-fall-through or registered with one cycle of latency; writes stall on full.
module yj_sync_fifo #(
    parameter int DW        = 32,
    parameter int AW        = 2,
    parameter int FWFT      = 1,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          w_en,
    input  logic [DW-1:0] w_data,
    output logic          w_ready,
    input  logic          r_en,
    output logic [DW-1:0] r_data,
    output logic          r_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow
);

    localparam int            DEPTH     = 2 ** AW;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_TH     = (AW+1)'(AFULL_TH);
    localparam logic [AW:0]   AE_TH     = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;

    // Flags come straight from the registered count so they all move together.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_TH);
    assign almost_empty = (count_q <= AE_TH);
    assign w_ready      = ~full;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = w_en & ~full;
    assign rd_acc = r_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_ONE;
        end
        // A fresh error in the same cycle as err_clr wins.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en && full) begin
            overflow_d = 1'b1;
        end
        if (r_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= w_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data  = empty ? '0 : mem[rd_ptr_q];
            assign r_valid = ~empty;
        end else begin : g_reg
            logic [DW-1:0] r_data_q;
            logic          r_valid_q;

            // r_data holds the last popped word; r_valid pulses once per pop.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= rd_acc;
                    if (rd_acc) begin
                        r_data_q <= mem[rd_ptr_q];
                    end
                end
            end

            assign r_data  = r_data_q;
            assign r_valid = r_valid_q;
        end
    endgenerate

endmodule
